// File: rtl/conv_pkg.sv
// Shared constants and state type for the 3x3 convolution engine.
// Coefficients are signed Q4.12; results are signed Q20.12.
package conv_pkg;
  localparam int IMG_W     = 28;
  localparam int IMG_H     = 28;
  localparam int PIX_W     = 8;
  localparam int COEF_W    = 16;
  localparam int COEF_FRAC = 12;
  localparam int ACC_W     = 32;
  localparam int N_PIX     = IMG_W * IMG_H;
  localparam int N_TAPS    = 9;
  localparam int PROD_W    = PIX_W + 1 + COEF_W;

  localparam logic signed [COEF_W-1:0] Q_ONE = 16'sd4096;

  typedef enum logic [1:0] {IDLE, RUN, DONE} conv_state_t;
endpackage

// File: rtl/conv_image_buffer.sv
// 28x28 pixel store: synchronous write, combinational read.
// Reads at negative or past-edge coordinates return 0, which gives zero padding.
module conv_image_buffer
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [9:0]        wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic signed [5:0] rd_row,
  input  logic signed [5:0] rd_col,
  output logic [PIX_W-1:0]  rd_data
);
  logic [PIX_W-1:0] mem [N_PIX];
  logic             in_range;
  logic [9:0]       rd_addr;

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < 10'(N_PIX))) mem[wr_addr] <= wr_data;
  end

  always_comb begin
    in_range = (rd_row >= 6'sd0) && (rd_row < 6'(IMG_H)) &&
               (rd_col >= 6'sd0) && (rd_col < 6'(IMG_W));
    rd_addr  = {5'b0, rd_row[4:0]} * 10'(IMG_W) + {5'b0, rd_col[4:0]};
    rd_data  = in_range ? mem[rd_addr] : '0;
  end
endmodule

// File: rtl/conv3x3_engine.sv
// Zero-padded 3x3 convolution over a 28x28 frame, one tap per cycle on one MAC.
// Results stream out in raster order; writes and start are ignored while busy.
module conv3x3_engine
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pix_we,
  input  logic [9:0]               pix_addr,
  input  logic [PIX_W-1:0]         pix_wdata,
  input  logic                     coef_we,
  input  logic [3:0]               coef_idx,
  input  logic signed [COEF_W-1:0] coef_wdata,
  input  logic                     start,
  output logic                     busy,
  output logic                     out_valid,
  output logic [4:0]               out_row,
  output logic [4:0]               out_col,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     done
);
  conv_state_t              state, state_next;
  logic [4:0]               row, col;
  logic [3:0]               tap;
  logic signed [ACC_W-1:0]  acc, acc_next;
  logic signed [COEF_W-1:0] coef [N_TAPS];
  logic [1:0]               tap_r, tap_c;
  logic signed [5:0]        tap_row, tap_col;
  logic [PIX_W-1:0]         pix;
  logic signed [PROD_W-1:0] prod;
  logic                     idle, last_tap, last_pix;

  assign idle = (state == IDLE);
  assign busy = !idle;

  conv_image_buffer u_img (
    .clk     (clk),
    .wr_en   (pix_we && idle),
    .wr_addr (pix_addr),
    .wr_data (pix_wdata),
    .rd_row  (tap_row),
    .rd_col  (tap_col),
    .rd_data (pix)
  );

  // Tap t covers neighbour (row + t/3 - 1, col + t%3 - 1).
  always_comb begin
    tap_r    = 2'(tap / 4'd3);
    tap_c    = 2'(tap % 4'd3);
    tap_row  = $signed({1'b0, row}) + $signed({4'b0, tap_r}) - 6'sd1;
    tap_col  = $signed({1'b0, col}) + $signed({4'b0, tap_c}) - 6'sd1;
    prod     = $signed({1'b0, pix}) * coef[tap];
    acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    last_tap = (tap == 4'(N_TAPS - 1));
    last_pix = (row == 5'(IMG_H - 1)) && (col == 5'(IMG_W - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_tap && last_pix) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      tap       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_data  <= '0;
      done      <= 1'b0;
      for (int i = 0; i < N_TAPS; i++) coef[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (coef_we && (coef_idx < 4'(N_TAPS))) coef[coef_idx] <= coef_wdata;
          if (start) begin
            row <= '0;
            col <= '0;
            tap <= '0;
            acc <= '0;
          end
        end
        RUN: begin
          if (last_tap) begin
            // Emit the finished sum and restart the accumulator in the same cycle.
            out_valid <= 1'b1;
            out_data  <= acc_next;
            out_row   <= row;
            out_col   <= col;
            acc       <= '0;
            tap       <= '0;
            if (col == 5'(IMG_W - 1)) begin
              col <= '0;
              row <= row + 5'd1;
            end else begin
              col <= col + 5'd1;
            end
          end else begin
            acc <= acc_next;
            tap <= tap + 4'd1;
          end
        end
        DONE:    done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv3x3_engine.sv
// Directed frames plus randomized frames, checked against a plain-arithmetic
// convolution model of the zero-padded 3x3 kernel.
module tb_conv3x3_engine;
  import conv_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pix_we;
  logic [9:0]        pix_addr;
  logic [7:0]        pix_wdata;
  logic              coef_we;
  logic [3:0]        coef_idx;
  logic signed [15:0] coef_wdata;
  logic              start;
  logic              busy;
  logic              out_valid;
  logic [4:0]        out_row;
  logic [4:0]        out_col;
  logic signed [31:0] out_data;
  logic              done;

  int checks = 0;
  int errors = 0;
  int img [784];
  int cf [9];
  logic [31:0] got [784];
  logic [31:0] exp_q [$];

  conv3x3_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_we     (pix_we),
    .pix_addr   (pix_addr),
    .pix_wdata  (pix_wdata),
    .coef_we    (coef_we),
    .coef_idx   (coef_idx),
    .coef_wdata (coef_wdata),
    .start      (start),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_data   (out_data),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Reference: direct zero-padded convolution over the model image and kernel.
  task automatic build_expected();
    exp_q.delete();
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        int s = 0;
        for (int t = 0; t < 9; t++) begin
          int rr = r + t / 3 - 1;
          int cc = c + t % 3 - 1;
          if (rr >= 0 && rr < 28 && cc >= 0 && cc < 28) s += img[rr * 28 + cc] * cf[t];
        end
        exp_q.push_back(32'(s));
      end
    end
  endtask

  task automatic write_image();
    for (int i = 0; i < 784; i++) begin
      pix_we = 1'b1; pix_addr = 10'(i); pix_wdata = 8'(img[i]);
      @(negedge clk);
    end
    pix_we = 1'b1; pix_addr = 10'd800; pix_wdata = 8'd99;
    @(negedge clk);
    pix_we = 1'b0;
  endtask

  task automatic write_coefs();
    for (int t = 0; t < 9; t++) begin
      coef_we = 1'b1; coef_idx = 4'(t); coef_wdata = 16'(cf[t]);
      @(negedge clk);
    end
    coef_we = 1'b1; coef_idx = 4'd12; coef_wdata = 16'sh7fff;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  // Start a frame at the next edge (edge k); n counts edges since k.
  task automatic run_frame(input string tag, input bit disturb, input int abort_at);
    int n = 0;
    int cnt = 0;
    bit fin = 0;
    bit saw_done = 0;
    logic [31:0] e;
    build_expected();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (!fin) begin
      if (out_valid) begin
        check({tag, "_valid_time"}, n, 9 + 9 * cnt);
        e = exp_q.pop_front();
        check({tag, "_data"}, out_data, e);
        check({tag, "_pos"}, {out_row, out_col}, {5'(cnt / 28), 5'(cnt % 28)});
        got[cnt] = out_data;
        cnt++;
        if (abort_at > 0 && cnt == abort_at) begin
          rst_n = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          check({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
          check({tag, "_rst_data"}, out_data, 32'd0);
          check({tag, "_rst_pos"}, {out_row, out_col}, 10'd0);
          check({tag, "_rst_busy"}, 32'(busy), 32'd0);
          for (int i = 0; i < 40; i++) begin
            if (done || out_valid) saw_done = 1;
            @(negedge clk);
          end
          check({tag, "_no_done_after_abort"}, 32'(saw_done), 32'd0);
          fin = 1;
        end
      end
      if (!fin && done) begin
        check({tag, "_done_time"}, n, 7057);
        check({tag, "_count"}, cnt, 784);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        fin = 1;
      end
      if (disturb && n < 7000) begin
        pix_we = 1'b1; pix_addr = 10'($urandom_range(0, 783)); pix_wdata = 8'($urandom);
        coef_we = 1'b1; coef_idx = 4'($urandom_range(0, 8)); coef_wdata = 16'($urandom);
        start = 1'($urandom_range(0, 1));
      end else begin
        pix_we = 1'b0; coef_we = 1'b0; start = 1'b0;
      end
      if (!fin) begin
        @(negedge clk);
        n++;
        if (n > 7200) begin
          errors++;
          $error("FAIL %s_timeout: observed %0d outputs expected 784 before bound", tag, cnt);
          fin = 1;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pix_we = 1'b0; pix_addr = '0; pix_wdata = '0;
    coef_we = 1'b0; coef_idx = '0; coef_wdata = '0; start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_data", out_data, 32'd0);
    check("reset_pos", {out_row, out_col}, 10'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Flat image, all-ones kernel: counts in-bounds neighbours.
    for (int i = 0; i < 784; i++) img[i] = 1;
    for (int t = 0; t < 9; t++) cf[t] = int'(Q_ONE);
    write_image(); write_coefs();
    run_frame("ones", 0, 0);
    check("ones_0_0", got[0], 16384);
    check("ones_0_5", got[5], 24576);
    check("ones_13_13", got[13 * 28 + 13], 36864);
    check("ones_27_27", got[783], 16384);

    // Ramp image, identity kernel.
    for (int r = 0; r < 28; r++) for (int c = 0; c < 28; c++) img[r * 28 + c] = r + c;
    for (int t = 0; t < 9; t++) cf[t] = (t == 4) ? 4096 : 0;
    write_image(); write_coefs();
    run_frame("ramp", 0, 0);
    check("ramp_27_27", got[783], 221184);

    // Saturated image with negative and extreme coefficients.
    for (int i = 0; i < 784; i++) img[i] = 255;
    for (int t = 0; t < 9; t++) cf[t] = (t == 4) ? -5120 : 0;
    write_image(); write_coefs();
    run_frame("neg", 0, 0);
    check("neg_14_3", got[14 * 28 + 3], -32'sd1305600);
    cf[0] = 32767; cf[4] = 32767;
    write_coefs();
    run_frame("max", 0, 0);
    check("max_1_1", got[29], 16711170);

    // Single hot pixel with top-left tap checks kernel orientation.
    for (int i = 0; i < 784; i++) img[i] = 0;
    img[5 * 28 + 7] = 200;
    for (int t = 0; t < 9; t++) cf[t] = (t == 0) ? 4096 : 0;
    write_image(); write_coefs();
    run_frame("hot", 0, 0);
    check("hot_6_8", got[6 * 28 + 8], 819200);
    check("hot_5_7", got[5 * 28 + 7], 0);

    // Random frame aborted by reset, then a zero-kernel run, then a disturbed rerun.
    for (int i = 0; i < 784; i++) img[i] = int'($urandom_range(0, 255));
    for (int t = 0; t < 9; t++) cf[t] = int'($signed(16'($urandom)));
    write_image(); write_coefs();
    run_frame("abort", 0, 100);
    for (int t = 0; t < 9; t++) cf[t] = 0;
    run_frame("cleared", 0, 0);
    for (int t = 0; t < 9; t++) cf[t] = int'($signed(16'($urandom)));
    write_coefs();
    run_frame("disturb", 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
